// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the ALU issue controller: FSM state encoding,
// datapath widths, ALU opcode constants and small helper functions.
package alu_ctrl_pkg;

    localparam int DATA_W   = 4;
    localparam int OP_W     = 3;
    localparam int REG_AW   = 2;
    localparam int NUM_REGS = 4;
    localparam int CNT_W    = 8;

    localparam logic [CNT_W-1:0] CNT_INC = 8'd1;

    // Opcodes understood by the external ALU
    localparam logic [OP_W-1:0] OP_ADD  = 3'b000;
    localparam logic [OP_W-1:0] OP_SUB  = 3'b001;
    localparam logic [OP_W-1:0] OP_AND  = 3'b010;
    localparam logic [OP_W-1:0] OP_OR   = 3'b011;
    localparam logic [OP_W-1:0] OP_XOR  = 3'b100;
    localparam logic [OP_W-1:0] OP_SHL  = 3'b101;
    localparam logic [OP_W-1:0] OP_SHR  = 3'b110;
    localparam logic [OP_W-1:0] OP_PASS = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        WB   = 2'b10
    } state_t;

    // Zero status of a data word, shared by the immediate-load path
    function automatic logic is_zero(input logic [DATA_W-1:0] data);
        return (data == {DATA_W{1'b0}});
    endfunction

endpackage

// File: rtl/alu_regfile.sv
// 4 x 4-bit register file for the ALU issue controller.
// Ports: clk/rst (synchronous active-high reset), one synchronous write port
// (we, waddr, wdata), two asynchronous operand read ports (raddr_a/rdata_a,
// raddr_b/rdata_b) and an asynchronous debug read port (dbg_addr/dbg_data).
// Reads always return the pre-write contents during a write cycle.
module alu_regfile
    import alu_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [REG_AW-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [REG_AW-1:0] raddr_a,
    output logic [DATA_W-1:0] rdata_a,
    input  logic [REG_AW-1:0] raddr_b,
    output logic [DATA_W-1:0] rdata_b,
    input  logic [REG_AW-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    logic [DATA_W-1:0] regs_r [NUM_REGS];

    // Register storage: clear on reset, single write port otherwise
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_r[i] <= {DATA_W{1'b0}};
            end
        end else if (we) begin
            regs_r[waddr] <= wdata;
        end
    end

    assign rdata_a  = regs_r[raddr_a];
    assign rdata_b  = regs_r[raddr_b];
    assign dbg_data = regs_r[dbg_addr];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Serial issue controller for an external 4-bit ALU.
// Ports: clk/rst (synchronous active-high); instruction handshake
// (instr_valid/instr_ready plus instr_ld/op/rd/rs1/rs2/imm); ALU interface
// (alu_a, alu_b, alu_opcode out; alu_result, alu_zero in); writeback
// (wb_valid strobe, wb_rd, wb_data); status (zero_flag, instr_count);
// debug read port (dbg_addr -> dbg_data).
// ALU ops walk IDLE->EXEC->WB->IDLE, immediate loads go IDLE->WB->IDLE.
// Only one instruction is ever in flight, so operand reads never race
// against a pending write.
module alu_issue_ctrl
    import alu_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic              instr_ld,
    input  logic [OP_W-1:0]   instr_op,
    input  logic [REG_AW-1:0] instr_rd,
    input  logic [REG_AW-1:0] instr_rs1,
    input  logic [REG_AW-1:0] instr_rs2,
    input  logic [DATA_W-1:0] instr_imm,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_opcode,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero,
    output logic              wb_valid,
    output logic [REG_AW-1:0] wb_rd,
    output logic [DATA_W-1:0] wb_data,
    output logic              zero_flag,
    output logic [CNT_W-1:0]  instr_count,
    input  logic [REG_AW-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    state_t            state_r;
    state_t            state_next_s;
    logic              accept_s;
    logic              load_alu_s;
    logic              load_imm_s;
    logic              capture_s;
    logic              commit_s;
    logic [DATA_W-1:0] rdata_a_s;
    logic [DATA_W-1:0] rdata_b_s;

    logic [DATA_W-1:0] alu_a_r;
    logic [DATA_W-1:0] alu_b_r;
    logic [OP_W-1:0]   alu_opcode_r;
    logic              wb_valid_r;
    logic [REG_AW-1:0] wb_rd_r;
    logic [DATA_W-1:0] wb_data_r;
    logic              wb_zero_r;
    logic              zero_flag_r;
    logic [CNT_W-1:0]  instr_count_r;

    // Ready is held low while reset is applied so nothing is accepted then
    assign instr_ready = (state_r == IDLE) && !rst;
    assign accept_s    = instr_valid && instr_ready;

    alu_regfile u_regfile (
        .clk      (clk),
        .rst      (rst),
        .we       (commit_s),
        .waddr    (wb_rd_r),
        .wdata    (wb_data_r),
        .raddr_a  (instr_rs1),
        .rdata_a  (rdata_a_s),
        .raddr_b  (instr_rs2),
        .rdata_b  (rdata_b_s),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state and datapath control decode
    always_comb begin
        state_next_s = state_r;
        load_alu_s   = 1'b0;
        load_imm_s   = 1'b0;
        capture_s    = 1'b0;
        commit_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    if (instr_ld) begin
                        state_next_s = WB;
                        load_imm_s   = 1'b1;
                    end else begin
                        state_next_s = EXEC;
                        load_alu_s   = 1'b1;
                    end
                end else begin
                    state_next_s = IDLE;
                end
            end
            EXEC: begin
                state_next_s = WB;
                capture_s    = 1'b1;
            end
            WB: begin
                state_next_s = IDLE;
                commit_s     = 1'b1;
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Datapath: operand issue, result capture, writeback and status
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_a_r       <= {DATA_W{1'b0}};
            alu_b_r       <= {DATA_W{1'b0}};
            alu_opcode_r  <= 3'b000;
            wb_valid_r    <= 1'b0;
            wb_rd_r       <= {REG_AW{1'b0}};
            wb_data_r     <= {DATA_W{1'b0}};
            wb_zero_r     <= 1'b0;
            zero_flag_r   <= 1'b0;
            instr_count_r <= {CNT_W{1'b0}};
        end else begin
            if (load_alu_s) begin
                alu_a_r      <= rdata_a_s;
                alu_b_r      <= rdata_b_s;
                alu_opcode_r <= instr_op;
                wb_rd_r      <= instr_rd;
            end
            // wb_valid is raised on entry to WB and dropped on the edge leaving it
            if (load_imm_s) begin
                wb_rd_r    <= instr_rd;
                wb_data_r  <= instr_imm;
                wb_zero_r  <= is_zero(instr_imm);
                wb_valid_r <= 1'b1;
            end else if (capture_s) begin
                wb_data_r  <= alu_result;
                wb_zero_r  <= alu_zero;
                wb_valid_r <= 1'b1;
            end else begin
                wb_valid_r <= 1'b0;
            end
            if (commit_s) begin
                zero_flag_r   <= wb_zero_r;
                instr_count_r <= instr_count_r + CNT_INC;
            end
        end
    end

    assign alu_a       = alu_a_r;
    assign alu_b       = alu_b_r;
    assign alu_opcode  = alu_opcode_r;
    assign wb_valid    = wb_valid_r;
    assign wb_rd       = wb_rd_r;
    assign wb_data     = wb_data_r;
    assign zero_flag   = zero_flag_r;
    assign instr_count = instr_count_r;

endmodule
